// File: rtl/bar_foo_reduce_stage_if.sv
// Operand and result handshake channels of the bar_foo reduce stage.
// master is the stage itself; slave is the surrounding environment.
interface bar_foo_reduce_stage_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             handshake_valid;
    logic             handshake_ready;
    logic             out;
    logic [WIDTH:0]   sum;

    modport master (
        input  in_valid, in1, in2, handshake_ready,
        output in_ready, handshake_valid, out, sum
    );

    modport slave (
        output in_valid, in1, in2, handshake_ready,
        input  in_ready, handshake_valid, out, sum
    );
endinterface

// File: rtl/bar_foo_reduce_stage.sv
// Reduces nibble pairs to a flag and a sum, buffering results
// in a small FIFO ahead of the handshake output channel.
module bar_foo_reduce_stage #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    bar_foo_reduce_stage_if.master  io,
    output logic [CW-1:0]           count,
    output logic [CNT_W-1:0]        txn_cnt
);

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [CNT_W-1:0] txn_q, txn_d;
    logic             flag_q [DEPTH];
    logic             flag_d [DEPTH];
    logic [WIDTH:0]   sum_q  [DEPTH];
    logic [WIDTH:0]   sum_d  [DEPTH];
    logic             push;
    logic             pop;
    logic             hv;

    always_comb begin
        hv         = (count_q != '0);
        io.in_ready = (count_q < CW'(DEPTH));
        push       = io.in_valid & io.in_ready;
        pop        = hv & io.handshake_ready;

        // Pointers wrap explicitly so DEPTH need not be a power of two
        wr_ptr_d = wr_ptr_q;
        if (push)
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q;
        if (pop)
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        txn_d = push ? txn_q + CNT_W'(1) : txn_q;

        flag_d = flag_q;
        sum_d  = sum_q;
        if (push) begin
            flag_d[wr_ptr_q] = (|io.in1) & (&io.in1) & io.in2[0];
            sum_d[wr_ptr_q]  = {1'b0, io.in1} + {1'b0, io.in2};
        end

        io.handshake_valid = hv;
        io.out = hv ? flag_q[rd_ptr_q] : 1'b0;
        io.sum = hv ? sum_q[rd_ptr_q] : '0;
        count   = count_q;
        txn_cnt = txn_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            txn_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            txn_q    <= txn_d;
        end
    end

    // Entry storage is only observable through count_q, so it needs no reset
    always_ff @(posedge CLK) begin
        flag_q <= flag_d;
        sum_q  <= sum_d;
    end

endmodule

// File: tb/tb_bar_foo_reduce_stage.sv
// Directed and scoreboard checks for bar_foo_reduce_stage.
// A second instance with CNT_W=2 exercises counter wrap.
module tb_bar_foo_reduce_stage;

    logic       clk = 1'b0;
    logic       rstn;
    logic [1:0] cnt_a;
    logic [7:0] txn_a;
    logic [1:0] cnt_b;
    logic [1:0] txn_b;

    bar_foo_reduce_stage_if #(.WIDTH(4)) ifa ();
    bar_foo_reduce_stage_if #(.WIDTH(4)) ifb ();

    bar_foo_reduce_stage #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) u_a (
        .CLK(clk), .RESETN(rstn), .io(ifa), .count(cnt_a), .txn_cnt(txn_a)
    );

    bar_foo_reduce_stage #(.WIDTH(4), .DEPTH(2), .CNT_W(2)) u_b (
        .CLK(clk), .RESETN(rstn), .io(ifb), .count(cnt_b), .txn_cnt(txn_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       o;
        logic [4:0] s;
    } vec_t;

    typedef struct {
        logic       o;
        logic [4:0] s;
    } res_t;

    int   checks = 0;
    int   errors = 0;
    int   mcount = 0;
    int   exp_txn = 0;
    res_t exp_q[$];
    vec_t vt[8];

    task automatic check(input string n, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", n, act, exp);
        end
    endtask

    function automatic res_t model(input logic [3:0] a, input logic [3:0] b);
        res_t r;
        r.o = (a == 4'hF) && b[0];
        r.s = 5'(a) + 5'(b);
        return r;
    endfunction

    // Check outputs against the model, then advance one clock
    task automatic cyc(input string tag);
        bit pu, po;
        pu = ifa.in_valid && (mcount < 2);
        po = (mcount != 0) && ifa.handshake_ready;
        check({tag, "_rdy"}, 32'(ifa.in_ready), 32'(mcount < 2));
        check({tag, "_hv"}, 32'(ifa.handshake_valid), 32'(mcount != 0));
        check({tag, "_cnt"}, 32'(cnt_a), 32'(mcount));
        check({tag, "_txn"}, 32'(txn_a), 32'(exp_txn));
        if (mcount != 0) begin
            check({tag, "_out"}, 32'(ifa.out), 32'(exp_q[0].o));
            check({tag, "_sum"}, 32'(ifa.sum), 32'(exp_q[0].s));
        end else begin
            check({tag, "_out0"}, 32'(ifa.out), 32'd0);
            check({tag, "_sum0"}, 32'(ifa.sum), 32'd0);
        end
        @(posedge clk);
        #1;
        if (po) void'(exp_q.pop_front());
        if (pu) begin
            exp_q.push_back(model(ifa.in1, ifa.in2));
            exp_txn = (exp_txn + 1) % 256;
        end
        mcount = exp_q.size();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        exp_q.delete();
        mcount = 0;
        exp_txn = 0;
    endtask

    initial begin
        int sent;
        logic [1:0] seq [5];
        ifa.in_valid = 1'b0;
        ifa.in1 = '0;
        ifa.in2 = '0;
        ifa.handshake_ready = 1'b1;
        ifb.in_valid = 1'b0;
        ifb.in1 = 4'h3;
        ifb.in2 = 4'h4;
        ifb.handshake_ready = 1'b1;
        rstn = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Idle after reset
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("rst_hv", 32'(ifa.handshake_valid), 32'd0);
        check("rst_out", 32'(ifa.out), 32'd0);
        check("rst_sum", 32'(ifa.sum), 32'd0);
        check("rst_rdy", 32'(ifa.in_ready), 32'd1);
        check("rst_txn", 32'(txn_a), 32'd0);
        check("rst_cnt", 32'(cnt_a), 32'd0);

        vt[0] = '{4'hF, 4'h1, 1'b1, 5'h10};
        vt[1] = '{4'h0, 4'h3, 1'b0, 5'h03};
        vt[2] = '{4'h7, 4'h9, 1'b0, 5'h10};
        vt[3] = '{4'hF, 4'hE, 1'b0, 5'h1D};
        vt[4] = '{4'hF, 4'hF, 1'b1, 5'h1E};
        vt[5] = '{4'h1, 4'h0, 1'b0, 5'h01};
        vt[6] = '{4'h0, 4'h0, 1'b0, 5'h00};
        vt[7] = '{4'hE, 4'h1, 1'b0, 5'h0F};

        // Single pushes with ready high: one-cycle latency, popped next edge
        ifa.handshake_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ifa.in1 = vt[i].a;
            ifa.in2 = vt[i].b;
            ifa.in_valid = 1'b1;
            cyc("tbl_push");
            ifa.in_valid = 1'b0;
            check($sformatf("tbl%0d_hv", i), 32'(ifa.handshake_valid), 32'd1);
            check($sformatf("tbl%0d_out", i), 32'(ifa.out), 32'(vt[i].o));
            check($sformatf("tbl%0d_sum", i), 32'(ifa.sum), 32'(vt[i].s));
            cyc("tbl_pop");
            check($sformatf("tbl%0d_cnt", i), 32'(cnt_a), 32'd0);
            check($sformatf("tbl%0d_txn", i), 32'(txn_a), 32'(i + 1));
        end

        // Backpressure: fill, block the third pair, then drain in order
        ifa.handshake_ready = 1'b0;
        ifa.in_valid = 1'b1;
        ifa.in1 = 4'h0; ifa.in2 = 4'h3;
        cyc("bp1");
        ifa.in1 = 4'h7; ifa.in2 = 4'h9;
        cyc("bp2");
        ifa.in1 = 4'hF; ifa.in2 = 4'hE;
        check("bp_full_rdy", 32'(ifa.in_ready), 32'd0);
        check("bp_full_cnt", 32'(cnt_a), 32'd2);
        check("bp_head_out", 32'(ifa.out), 32'd0);
        check("bp_head_sum", 32'(ifa.sum), 32'h03);
        cyc("bp_hold");
        check("bp_stable_sum", 32'(ifa.sum), 32'h03);
        check("bp_stable_cnt", 32'(cnt_a), 32'd2);
        ifa.handshake_ready = 1'b1;
        cyc("bp_pop1");
        check("bp_d1_cnt", 32'(cnt_a), 32'd1);
        check("bp_d1_sum", 32'(ifa.sum), 32'h10);
        cyc("bp_pushpop");
        ifa.in_valid = 1'b0;
        check("bp_d2_cnt", 32'(cnt_a), 32'd1);
        check("bp_d2_out", 32'(ifa.out), 32'd0);
        check("bp_d2_sum", 32'(ifa.sum), 32'h1D);
        cyc("bp_pop3");
        check("bp_empty_hv", 32'(ifa.handshake_valid), 32'd0);

        // Streaming through a full FIFO against the scoreboard
        ifa.handshake_ready = 1'b0;
        ifa.in_valid = 1'b1;
        sent = 0;
        for (int i = 0; i < 2; i++) begin
            ifa.in1 = 4'($urandom_range(0, 15));
            ifa.in2 = 4'($urandom_range(0, 15));
            cyc("pre");
            sent++;
        end
        ifa.handshake_ready = 1'b1;
        ifa.in1 = 4'($urandom_range(0, 15));
        ifa.in2 = 4'($urandom_range(0, 15));
        for (int i = 0; i < 400 && (sent < 50 || mcount != 0); i++) begin
            bit pu;
            pu = ifa.in_valid && (mcount < 2);
            cyc("strm");
            if (pu) begin
                sent++;
                ifa.in1 = 4'($urandom_range(0, 15));
                ifa.in2 = 4'($urandom_range(0, 15));
                if (sent >= 50) ifa.in_valid = 1'b0;
            end
        end
        ifa.in_valid = 1'b0;
        check("strm_sent", 32'(sent), 32'd50);
        check("strm_cnt", 32'(cnt_a), 32'd0);
        check("strm_hv", 32'(ifa.handshake_valid), 32'd0);

        // Reset while full with a pair pending
        do_reset();
        ifa.handshake_ready = 1'b0;
        ifa.in_valid = 1'b1;
        ifa.in1 = 4'h2; ifa.in2 = 4'h5;
        cyc("mr1");
        ifa.in1 = 4'hF; ifa.in2 = 4'h3;
        cyc("mr2");
        ifa.in1 = 4'h9; ifa.in2 = 4'h1;
        check("mr_pre_cnt", 32'(cnt_a), 32'd2);
        ifa.handshake_ready = 1'b1;
        do_reset();
        check("mr_cnt", 32'(cnt_a), 32'd0);
        check("mr_hv", 32'(ifa.handshake_valid), 32'd0);
        check("mr_txn", 32'(txn_a), 32'd0);
        check("mr_out", 32'(ifa.out), 32'd0);
        check("mr_sum", 32'(ifa.sum), 32'd0);
        ifa.in_valid = 1'b0;
        cyc("mr_idle1");
        cyc("mr_idle2");

        // CNT_W=2 wrap on back-to-back pushes
        seq[0] = 2'd1; seq[1] = 2'd2; seq[2] = 2'd3; seq[3] = 2'd0; seq[4] = 2'd1;
        check("w_txn0", 32'(txn_b), 32'd0);
        ifb.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("w_txn%0d", i + 1), 32'(txn_b), 32'(seq[i]));
        end
        ifb.in_valid = 1'b0;
        check("w_cnt", 32'(cnt_b), 32'd1);
        check("w_sum", 32'(ifb.sum), 32'h07);
        check("w_out", 32'(ifb.out), 32'd0);
        check("w_rdy", 32'(ifb.in_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bar_foo_reduce_stage.md
Name: bar_foo_reduce_stage

Overview:
Producer stage that sits directly upstream of the RTL block watched by the bar_foo monitor. It accepts nibble pairs (in1, in2) on a ready/valid input channel and computes a reduced flag and a 5-bit sum. Results are buffered in a small FIFO and presented on the handshake output channel, which drives handshake_valid/handshake_ready and out as the monitor sees them. A wrapping transaction counter is exposed for debug.

Parameters:
WIDTH, 4, operand width of in1/in2
DEPTH, 2, output FIFO depth in entries (legal 2..8)
CNT_W, 8, width of the accepted-transaction counter

Ports:
CLK  input  1  clock, all state updates on posedge
RESETN  input  1  synchronous active-low reset, sampled on posedge CLK
in_valid  input  1  upstream operand valid
in_ready  output  1  stage can accept an operand pair
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
handshake_valid  output  1  result at FIFO head is valid
handshake_ready  input  1  downstream accepts the head result
out  output  1  reduced flag of the head result
sum  output  WIDTH+1  in1+in2 of the head result, zero-extended
count  output  $clog2(DEPTH+1)  current FIFO occupancy
txn_cnt  output  CNT_W  number of accepted operand pairs, mod 2^CNT_W

Behaviour:
- Reset: when RESETN=0 at a posedge, the FIFO empties, the read and write pointers go to 0, txn_cnt goes to 0, and occupancy goes to 0. After that edge handshake_valid=0, out=0, sum=0, and in_ready=1. Reset mid-transfer discards all buffered results; nothing is replayed. A push and a pop in the reset cycle are both ignored.
- Input handshake: the push condition is in_valid & in_ready at a posedge. in_ready = (count < DEPTH). in_ready is a function of registered state only and has no combinational path from handshake_ready.
- Per-entry arithmetic, evaluated on the pushed operands:
  - t1 = |in1
  - t2 = (&in1) & in2[0]
  - out = t1 & t2
  - sum = {1'b0,in1} + {1'b0,in2}, full WIDTH+1 bits, no truncation
- Output handshake: the pop condition is handshake_valid & handshake_ready at a posedge. handshake_valid = (count != 0). out and sum come straight from the head entry register; there is no combinational path from the in_* ports.
- Latency: a pair pushed at edge N into an empty FIFO is visible with handshake_valid=1 in the cycle after edge N. Minimum latency is 1 cycle.
- Stability: while handshake_valid=1 and handshake_ready=0, out and sum hold stable. Downstream assertions rely on this.
- Simultaneous push and pop:
  - count unchanged, both pointers advance.
  - This is legal when full: in_ready is already 0, so no push occurs and the pop proceeds alone.
  - This is legal when empty: no pop can occur, so the push proceeds alone. There is no bypass; the empty-FIFO result still appears one cycle later.
- Pointers: wrap modulo DEPTH. DEPTH need not be a power of two; the wrap is explicit compare-and-clear.
- txn_cnt: increments by 1 on every push and wraps 2^CNT_W-1 -> 0 with no flag.
- Output values when empty: when handshake_valid=0, out and sum are driven 0 rather than stale data.
- Protocol assumptions:
  - Once in_valid rises it holds, with in1/in2 stable, until accepted.
  - Upstream dropping in_valid without a handshake is tolerated and is not an error.

Test Plan:
- Reset, then in_valid=0 for 3 cycles -> handshake_valid=0, out=0, sum=0, in_ready=1, txn_cnt=0, count=0.
- Push in1=4'hF, in2=4'h1 with handshake_ready=1 -> next cycle handshake_valid=1, out=1, sum=5'h10; popped on that edge; count returns to 0; txn_cnt=1.
- handshake_ready=0, push (4'h0,4'h3), (4'h7,4'h9), (4'hF,4'hE) -> the first two are accepted and count=2. in_ready=0 blocks the third. Head stays out=0, sum=5'h03. Raise ready -> results drain in order: out=0/sum=5'h03, then out=0/sum=5'h10, then the third pair is accepted with out=0 (in2[0]=0), sum=5'h1D.
- Full FIFO with in_valid=1 and handshake_ready=1 held -> one result per cycle. count stays at DEPTH-1 or DEPTH, with no loss or duplication, checked by a scoreboard over 50 random pairs.
- RESETN=0 for one cycle while count=2 and in_valid=1 -> next cycle count=0, handshake_valid=0, and txn_cnt=0. The pending pair is not counted.
- CNT_W=2: 5 consecutive pushes -> txn_cnt sequence 1, 2, 3, 0, 1.
